// File: rtl/irrigation_zone_scheduler.sv
// Shared-tank irrigation sequencer: tank refill, round-robin zone runs, fertiliser
// injection with a follow-up clean flush, and a sticky fault on bad sensors or refill timeout.
module irrigation_zone_scheduler #(
  parameter int ZONES        = 4,
  parameter int LEVEL_W      = 3,
  parameter int MIN_LEVEL    = 1,
  parameter int TIMER_W      = 8,
  parameter int DRIP_TICKS   = 40,
  parameter int SPRINK_TICKS = 20,
  parameter int CLEAN_TICKS  = 10,
  parameter int FILL_TIMEOUT = 200
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic [ZONES-1:0]   zone_req,
  input  logic [ZONES-1:0]   zone_mode,
  input  logic               fert_req,
  input  logic [LEVEL_W-1:0] level,
  output logic               fill_valve,
  output logic [ZONES-1:0]   zone_valve,
  output logic               fert_valve,
  output logic [2:0]         active_zone,
  output logic [2:0]         state,
  output logic               err
);

  localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;
  localparam int LW = $clog2(LEVEL_W + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_IRR   = 3'd2,
    S_CLEAN = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t             cur, nxt, ret, ret_n;
  logic [TIMER_W-1:0] timer, timer_n, fill_timer, fill_n;
  logic [ZW-1:0]      act, act_n, rr, rr_n, gnt, cand;
  logic               clean_pending, cp_n, cp_eff, found;
  logic [LW-1:0]      lvl;
  logic [LEVEL_W:0]   lx;
  logic               valid, empty, full;

  always_comb begin
    lvl = '0;
    for (int unsigned i = 0; i < LEVEL_W; i++) lvl = lvl + LW'(level[i]);
    lx    = {1'b0, level};
    // thermometer codes are exactly the all-ones-from-bit0 patterns
    valid = ((lx + (LEVEL_W + 1)'(1)) & lx) == '0;
    empty = lvl == '0;
    full  = int'(lvl) == LEVEL_W;
  end

  always_comb begin
    gnt   = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= ZONES; i++) begin
      cand = ZW'((32'(rr) + i) % ZONES);
      if (!found && zone_req[cand]) begin
        gnt   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    nxt     = cur;
    ret_n   = ret;
    timer_n = timer;
    fill_n  = fill_timer;
    act_n   = act;
    rr_n    = rr;
    // fert_valve is registered, so the flag it sets is seen one cycle late; fold it in here
    cp_eff  = clean_pending | fert_valve;
    cp_n    = cp_eff;
    case (cur)
      S_IDLE: begin
        if (!valid) nxt = S_ERR;
        else if (clean_pending) begin
          nxt     = S_CLEAN;
          timer_n = TIMER_W'(CLEAN_TICKS);
        end else if (|zone_req) begin
          if (int'(lvl) < MIN_LEVEL) begin
            nxt   = S_FILL;
            ret_n = S_IDLE;
          end else begin
            nxt     = S_IRR;
            act_n   = gnt;
            timer_n = zone_mode[gnt] ? TIMER_W'(SPRINK_TICKS) : TIMER_W'(DRIP_TICKS);
          end
        end
      end
      S_FILL: begin
        if (!valid) nxt = S_ERR;
        else if (full) nxt = ret;
        else if (fill_timer == TIMER_W'(FILL_TIMEOUT)) nxt = S_ERR;
        else if (tick) fill_n = fill_timer + TIMER_W'(1);
      end
      S_IRR: begin
        if (!valid) nxt = S_ERR;
        else if (empty) begin
          nxt   = S_FILL;
          ret_n = S_IRR;
        end else if (timer == '0 || !zone_req[act]) begin
          rr_n = act;
          if (cp_eff) begin
            nxt     = S_CLEAN;
            timer_n = TIMER_W'(CLEAN_TICKS);
          end else begin
            nxt = S_IDLE;
          end
        end else if (tick) timer_n = timer - TIMER_W'(1);
      end
      S_CLEAN: begin
        if (!valid) nxt = S_ERR;
        else if (empty) begin
          nxt   = S_FILL;
          ret_n = S_CLEAN;
        end else if (timer == '0) begin
          cp_n = 1'b0;
          nxt  = S_IDLE;
        end else if (tick) timer_n = timer - TIMER_W'(1);
      end
      S_ERR:   nxt = S_ERR;
      default: nxt = S_ERR;
    endcase
    if (nxt == S_FILL && cur != S_FILL) fill_n = '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur           <= S_IDLE;
      ret           <= S_IDLE;
      timer         <= '0;
      fill_timer    <= '0;
      act           <= '0;
      rr            <= ZW'(ZONES - 1);
      clean_pending <= 1'b0;
      fill_valve    <= 1'b0;
      zone_valve    <= '0;
      fert_valve    <= 1'b0;
      err           <= 1'b0;
    end else begin
      cur           <= nxt;
      ret           <= ret_n;
      timer         <= timer_n;
      fill_timer    <= fill_n;
      act           <= act_n;
      rr            <= rr_n;
      clean_pending <= cp_n;
      fill_valve    <= (nxt == S_FILL);
      zone_valve    <= (nxt == S_IRR || nxt == S_CLEAN) ? (ZONES'(1) << act_n) : '0;
      fert_valve    <= (nxt == S_IRR) && fert_req && !zone_mode[act_n];
      err           <= (nxt == S_ERR);
    end
  end

  assign state       = cur;
  assign active_zone = 3'(act);

endmodule
